// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// and hands one instruction at a time to decode with a valid qualifier.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCResult,
    input  logic        stall,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_ISSUE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [7:0]  wait_q;
    logic        err_q;
    logic [31:0] pc_d;

    // Address of the instruction that follows the one currently issued.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (PCSrc) begin
            pc_d = PCResult & 32'hFFFF_FFFC;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch sequencer: a request completes on ack, or times out into a sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    // An ack in the timeout cycle still completes the fetch.
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        wait_q  <= 8'd0;
                        state_q <= S_ISSUE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    // Outputs decode the state register; rst low forces the idle/no-instruction view.
    assign imem_req    = rst & (state_q == S_REQ);
    assign instr_valid = rst & (state_q == S_ISSUE);
    assign imem_addr   = pc_q;
    assign Instr       = instr_valid ? instr_q : NOP_WORD;
    assign PC          = pc_q;
    assign PCPlus8     = pc_q + 32'd8;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: instance A (defaults) covers reset, streaming, redirect and stall;
// instance B (RESET_PC=FFFF_FFFC, MAX_WAIT=4) covers wait states, wrap and timeout.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic        a_rst, a_req, a_ack, a_ack_en, a_pcsrc, a_stall, a_valid, a_err;
    logic [31:0] a_addr, a_rdata, a_pcres, a_instr, a_pc, a_pc8;
    // Instance B signals
    logic        b_rst, b_req, b_ack, b_pcsrc, b_stall, b_valid, b_err;
    logic [31:0] b_addr, b_rdata, b_pcres, b_instr, b_pc, b_pc8;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'hE3A0_1005;
            32'h0000_0004: mem_word = 32'hE281_1001;
            32'h0000_0008: mem_word = 32'hE081_2001;
            default:       mem_word = 32'hA500_0000 | addr;
        endcase
    endfunction

    assign a_ack   = a_ack_en & a_req;
    assign a_rdata = mem_word(a_addr);

    fetch_unit dut_a (
        .clk(clk), .rst(a_rst), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .PCSrc(a_pcsrc), .PCResult(a_pcres),
        .stall(a_stall), .Instr(a_instr), .instr_valid(a_valid), .PC(a_pc),
        .PCPlus8(a_pc8), .fetch_err(a_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst(b_rst), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .PCSrc(b_pcsrc), .PCResult(b_pcres),
        .stall(b_stall), .Instr(b_instr), .instr_valid(b_valid), .PC(b_pc),
        .PCPlus8(b_pc8), .fetch_err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic req, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc);
        check({tag, ".req"},   32'(a_req),   32'(req));
        check({tag, ".valid"}, 32'(a_valid), 32'(valid));
        check({tag, ".instr"}, a_instr, instr);
        check({tag, ".pc"},    a_pc, pc);
        check({tag, ".addr"},  a_addr, pc);
        check({tag, ".pc8"},   a_pc8, pc + 32'd8);
    endtask

    task automatic chk_b(input string tag, input logic req, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc, input logic err);
        check({tag, ".req"},   32'(b_req),   32'(req));
        check({tag, ".valid"}, 32'(b_valid), 32'(valid));
        check({tag, ".instr"}, b_instr, instr);
        check({tag, ".pc"},    b_pc, pc);
        check({tag, ".err"},   32'(b_err),   32'(err));
    endtask

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    initial begin
        a_rst = 1'b0; a_ack_en = 1'b1; a_pcsrc = 1'b0; a_stall = 1'b0; a_pcres = 32'd0;
        b_rst = 1'b0; b_ack = 1'b0; b_pcsrc = 1'b0; b_stall = 1'b0; b_pcres = 32'd0;
        b_rdata = 32'd0;

        // Reset held for two edges
        tick(); tick();
        chk_a("rst", 1'b0, 1'b0, NOP, 32'h0);
        check("rst.err", 32'(a_err), 32'd0);
        a_rst = 1'b1;
        #1;
        chk_a("rel", 1'b1, 1'b0, NOP, 32'h0);

        // Zero-wait streaming
        tick(); chk_a("zw0.iss", 1'b0, 1'b1, 32'hE3A0_1005, 32'h0);
        tick(); chk_a("zw1.req", 1'b1, 1'b0, NOP, 32'h4);
        tick(); chk_a("zw1.iss", 1'b0, 1'b1, 32'hE281_1001, 32'h4);
        tick(); chk_a("zw2.req", 1'b1, 1'b0, NOP, 32'h8);
        tick(); chk_a("zw2.iss", 1'b0, 1'b1, 32'hE081_2001, 32'h8);
        tick(); tick(); tick();
        chk_a("pc10.req", 1'b1, 1'b0, NOP, 32'h10);
        tick(); chk_a("pc10.iss", 1'b0, 1'b1, 32'hA500_0010, 32'h10);

        // Redirect with misaligned target
        a_pcsrc = 1'b1; a_pcres = 32'h0000_0103;
        tick(); chk_a("redir", 1'b1, 1'b0, NOP, 32'h100);
        a_pcsrc = 1'b0;
        tick(); chk_a("redir.iss", 1'b0, 1'b1, 32'hA500_0100, 32'h100);
        tick(); chk_a("seq", 1'b1, 1'b0, NOP, 32'h104);
        tick(); chk_a("seq.iss", 1'b0, 1'b1, 32'hA500_0104, 32'h104);

        // Stall suppresses the pending redirect
        a_stall = 1'b1; a_pcsrc = 1'b1; a_pcres = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_a("stall", 1'b0, 1'b1, 32'hA500_0104, 32'h104);
        end
        a_stall = 1'b0; a_pcsrc = 1'b0;
        tick(); chk_a("unstall", 1'b1, 1'b0, NOP, 32'h108);

        // Instance B: wait states with ack in the would-be timeout cycle
        tick();
        b_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk_b("wait", 1'b1, 1'b0, NOP, 32'hFFFF_FFFC, 1'b0);
            check("wait.addr", b_addr, 32'hFFFF_FFFC);
            tick();
        end
        chk_b("wait4", 1'b1, 1'b0, NOP, 32'hFFFF_FFFC, 1'b0);
        b_ack = 1'b1; b_rdata = 32'h1234_5678;
        tick(); chk_b("wrap.iss", 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0);
        check("wrap.pc8", b_pc8, 32'h0000_0004);
        b_ack = 1'b0; b_rdata = 32'h0;
        tick(); chk_b("wrap.req", 1'b1, 1'b0, NOP, 32'h0, 1'b0);
        check("wrap.addr", b_addr, 32'h0);

        // Timeout: four unanswered REQ cycles
        tick(); tick(); tick();
        chk_b("to.pre", 1'b1, 1'b0, NOP, 32'h0, 1'b0);
        tick(); chk_b("to.err", 1'b0, 1'b0, NOP, 32'h0, 1'b1);
        b_ack = 1'b1; b_rdata = 32'hDEAD_BEEF;
        tick(); chk_b("to.late", 1'b0, 1'b0, NOP, 32'h0, 1'b1);
        tick(); chk_b("to.hold", 1'b0, 1'b0, NOP, 32'h0, 1'b1);
        b_ack = 1'b0;
        b_rst = 1'b0;
        tick(); chk_b("to.rst", 1'b0, 1'b0, NOP, 32'hFFFF_FFFC, 1'b0);
        check("to.rst.pc8", b_pc8, 32'h0000_0004);
        b_rst = 1'b1;
        #1; chk_b("to.rel", 1'b1, 1'b0, NOP, 32'hFFFF_FFFC, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit. Holds the architectural PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word plus a valid flag to decode/control. Consumes PCSrc and the branch/result target from the execute side to redirect fetch. Also supplies PC+8 for R15 operand reads.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
MAX_WAIT, 15, REQ-state cycles without ack before the fetch-timeout error; range 1..255.
NOP_WORD, 32'hE1A0_0000, word driven on Instr while no valid instruction is held (MOV r0,r0).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  memory has imem_rdata valid this cycle; may rise in the same cycle as imem_req
imem_rdata  in  32  instruction word, sampled only when imem_req && imem_ack
PCSrc  in  1  redirect request from control unit
PCResult  in  32  redirect target; bits [1:0] ignored
stall  in  1  downstream not ready; holds the issued instruction
Instr  out  32  instruction to decode/control unit
instr_valid  out  1  Instr is a fetched instruction being executed this cycle
PC  out  32  address of the current or pending instruction
PCPlus8  out  32  PC+8 (R15 read value), combinational from PC register
fetch_err  out  1  sticky fetch-timeout flag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port rst.
- Reset (rst==0 at edge): state=REQ; PC=RESET_PC; Instr reg=NOP_WORD; wait_cnt=0; fetch_err=0. Outputs while rst==0: imem_req=0, instr_valid=0, Instr=NOP_WORD, PCPlus8=RESET_PC+8. Reset mid-transaction aborts it; any late ack is ignored.
- States: REQ, ISSUE, ERR.
- REQ: imem_req=1, imem_addr=PC, instr_valid=0, Instr=NOP_WORD.
  - On imem_ack: capture imem_rdata, clear wait_cnt, go to ISSUE.
  - Otherwise: increment wait_cnt. When wait_cnt reaches MAX_WAIT-1 without ack, go to ERR and set fetch_err on that edge.
- ISSUE: imem_req=0, instr_valid=1, Instr=captured word.
  - stall=1: hold state, PC and Instr; PCSrc/PCResult are ignored.
  - stall=0: PC <= PCSrc ? {PCResult[31:2],2'b00} : PC+4; go to REQ.
- ERR: imem_req=0, instr_valid=0, Instr=NOP_WORD, fetch_err=1. Only reset exits ERR.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. PCPlus8 also wraps.
- Latency: ack seen at edge N gives instr_valid=1 in cycle N+1. Zero-wait memory gives one instruction per 2 cycles.
- imem_addr and imem_req are registered-state driven and stable through wait states. imem_rdata is don't-care outside ack.
- Simultaneous events:
  - PCSrc with stall=1: no redirect.
  - PCSrc outside ISSUE: ignored.
  - ack on the same cycle the timeout would fire: ack wins and the state goes to ISSUE.
- Downstream must qualify RegWrite/MemWrite with instr_valid. NOP_WORD keeps decode harmless otherwise.

Test Plan:
1. Reset: rst=0 for 2 cycles -> imem_req=0, instr_valid=0, Instr=E1A00000, PC=0, PCPlus8=8. Release -> same cycle imem_req=1, imem_addr=0.
2. Zero-wait sequence: ack same cycle, mem[0]=E3A01005, mem[4]=E2811001, mem[8]=E0812001 -> instr_valid pattern 0,1,0,1,0,1; Instr matches each word; PC 0,4,8; PCPlus8 8,12,16.
3. Redirect: ISSUE at PC=0x10, stall=0, PCSrc=1, PCResult=0x103 -> next imem_addr=0x100. Same case with PCSrc=0 -> 0x14.
4. Stall: in ISSUE, stall=1 for 3 cycles with PCSrc=1, PCResult=0x200 -> Instr/PC/instr_valid held, imem_req=0. On stall=0 with PCSrc=0, next addr is PC+4, no redirect.
5. Wait states and wrap: RESET_PC=FFFF_FFFC, ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles, then ISSUE. Next fetch addr=0.
6. Timeout and reset: MAX_WAIT=4, ack never -> fetch_err=1 after 4 REQ cycles, imem_req=0, Instr=NOP_WORD. A later ack is ignored. rst=0 then release -> fetch_err=0, PC=RESET_PC, fetch restarts.
